uart_rx_fifo: RTL and testbench

- Bench-side and FPGA-side UART receiver that consumes the serial `uart_txd` line driven by the SoC top wrapper.
- Deserialises 8N1 frames (optionally 8E1), checks framing, and buffers received bytes in a small FIFO.
- Hands bytes out through a valid/ready interface to a console logger or a host bridge.
- Sits directly downstream of the system top's UART transmit pin, and runs on the same clock as the system.

---
 rtl/uart_rx_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through FIFO with a valid/ready read port.
module uart_rx_fifo #(
    parameter int CYCLES_PER_BIT = 868,
    parameter int DEPTH          = 16
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     uart_rxd,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [7:0]               rx_data,
    output logic                     rx_err_frame,
    output logic                     rx_err_overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT1      = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
    logic par_ok_r, par_ok_s;
`endif

    logic            sync1_r, sync2_r, prev_r;
    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [2:0]      bit_idx_r, bit_idx_s;
    logic [7:0]      shift_r, shift_s;
    logic            push_s, frame_err_s;
    logic            err_frame_r, err_ovf_r;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [AW:0]     count_r;
    logic            pop_s, wr_en_s, ovf_s;

    // Line synchroniser, receive FSM state and error pulse registers
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            sync1_r     <= 1'b1;
            sync2_r     <= 1'b1;
            prev_r      <= 1'b1;
            state_r     <= S_IDLE;
            cnt_r       <= {CW{1'b0}};
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'd0;
            err_frame_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok_r    <= 1'b0;
`endif
        end else begin
            sync1_r     <= uart_rxd;
            sync2_r     <= sync1_r;
            prev_r      <= sync2_r;
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_idx_r   <= bit_idx_s;
            shift_r     <= shift_s;
            err_frame_r <= frame_err_s;
`ifdef UART_RX_PARITY_EN
            par_ok_r    <= par_ok_s;
`endif
        end
    end

    // Receive FSM next-state: each bit is sampled when the down-counter hits zero
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_idx_s   = bit_idx_r;
        shift_s     = shift_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_s    = par_ok_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (prev_r && !sync2_r) begin
                    cnt_s   = HALF_LOAD;
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (!sync2_r) begin
                    cnt_s     = FULL_LOAD;
                    bit_idx_s = 3'd0;
                    state_s   = S_DATA;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_s     = FULL_LOAD;
                    shift_s   = {sync2_r, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        state_s = S_DATA;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_s    = FULL_LOAD;
                    par_ok_s = (sync2_r == even_parity(shift_r));
                    state_s  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (sync2_r) begin
`ifdef UART_RX_PARITY_EN
                    if (par_ok_r) begin
                        push_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
`else
                    push_s = 1'b1;
`endif
                    state_s = S_IDLE;
                end else begin
                    frame_err_s = 1'b1;
                    state_s     = S_BREAK;
                end
            end
            S_BREAK: begin
                if (sync2_r) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_BREAK;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    assign pop_s   = (count_r != {(AW+1){1'b0}}) && rx_ready;
    assign wr_en_s = push_s && ((count_r != FULL_CNT) || pop_s);
    assign ovf_s   = push_s && !wr_en_s;

    // FIFO storage, pointers and occupancy; a full FIFO still accepts a push paired with a pop
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {(AW+1){1'b0}};
            err_ovf_r <= 1'b0;
        end else begin
            err_ovf_r <= ovf_s;
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT1;
                2'b01:   count_r <= count_r - CNT1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rx_valid        = (count_r != {(AW+1){1'b0}});
    assign rx_data         = mem_r[rd_ptr_r];
    assign fifo_count      = count_r;
    assign rx_err_frame    = err_frame_r;
    assign rx_err_overflow = err_ovf_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (CYCLES_PER_BIT=16, DEPTH=4).
// Honours UART_RX_PARITY_EN to match the frame format of the design build.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       g_clk = 1'b0;
    logic       g_resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err_frame;
    logic       rx_err_overflow;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int n_ferr = 0;
    int n_ovf = 0;
    int ferr0, ovf0;
    logic [7:0] popped[$];

    uart_rx_fifo #(.CYCLES_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .g_clk(g_clk),
        .g_resetn(g_resetn),
        .uart_rxd(uart_rxd),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_err_frame(rx_err_frame),
        .rx_err_overflow(rx_err_overflow),
        .fifo_count(fifo_count)
    );

    always #5 g_clk = ~g_clk;

    // Observe pulses and handshakes mid-cycle
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (rx_err_frame) n_ferr++;
            if (rx_err_overflow) n_ovf++;
            if (rx_valid && rx_ready) popped.push_back(rx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge g_clk);
        #1;
    endtask

    // Drives start, data, (parity) and leaves the stop level on the line;
    // the stop sample then lands 11 cycles after return.
    task automatic send_head(input logic [7:0] d, input logic par, input logic stop_bit);
        uart_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = par;
        tick(CPB);
`else
        if (par) uart_rxd = 1'b0;
`endif
        uart_rxd = stop_bit;
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_head(d, ^d, 1'b1);
        uart_rxd = 1'b1;
        tick(CPB);
    endtask

    initial begin
        tick(5);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ferr", 32'(rx_err_frame), 32'd0);
        check("rst_ovf", 32'(rx_err_overflow), 32'd0);
        g_resetn = 1'b1;
        tick(5);

        // Single byte, exact rx_valid timing around the stop sample
        send_head(8'hA5, ^8'hA5, 1'b1);
        tick(10);
        check("single_pre_valid", 32'(rx_valid), 32'd0);
        tick(1);
        check("single_valid", 32'(rx_valid), 32'd1);
        check("single_data", 32'(rx_data), 32'hA5);
        check("single_count", 32'(fifo_count), 32'd1);
        tick(15);
        check("single_ferr", 32'(n_ferr), 32'd0);
        check("single_ovf", 32'(n_ovf), 32'd0);

        // Reset flushes the FIFO
        g_resetn = 1'b0;
        tick(2);
        g_resetn = 1'b1;
        tick(2);
        check("rst_flush_count", 32'(fifo_count), 32'd0);
        check("rst_flush_data", 32'(rx_data), 32'h00);

        // Back-to-back burst with consumer always ready
        rx_ready = 1'b1;
        popped.delete();
        send_frame(8'h00);
        send_frame(8'hFF);
        send_frame(8'h55);
        send_frame(8'h81);
        tick(20);
        check("burst_n", 32'(popped.size()), 32'd4);
        check("burst_0", 32'(popped[0]), 32'h00);
        check("burst_1", 32'(popped[1]), 32'hFF);
        check("burst_2", 32'(popped[2]), 32'h55);
        check("burst_3", 32'(popped[3]), 32'h81);
        check("burst_count", 32'(fifo_count), 32'd0);

        // Overflow: six bytes into a four-entry FIFO
        rx_ready = 1'b0;
        popped.delete();
        ovf0 = n_ovf;
        for (int i = 0; i < 6; i++) send_frame(8'h10 + 8'(i));
        tick(20);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_pulses", 32'(n_ovf - ovf0), 32'd2);
        check("ovf_head", 32'(rx_data), 32'h10);
        rx_ready = 1'b1;
        tick(10);
        rx_ready = 1'b0;
        check("ovf_drain_n", 32'(popped.size()), 32'd4);
        check("ovf_drain_0", 32'(popped[0]), 32'h10);
        check("ovf_drain_3", 32'(popped[3]), 32'h13);
        check("ovf_drain_count", 32'(fifo_count), 32'd0);

        // Full FIFO with a pop coinciding with the fifth stop sample
        popped.delete();
        for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i));
        ovf0 = n_ovf;
        send_head(8'h24, ^8'h24, 1'b1);
        tick(10);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("fullpop_count", 32'(fifo_count), 32'd4);
        check("fullpop_popped", 32'(popped.size()), 32'd1);
        check("fullpop_head", 32'(rx_data), 32'h21);
        tick(5);
        tick(10);
        check("fullpop_ovf", 32'(n_ovf - ovf0), 32'd0);
        rx_ready = 1'b1;
        tick(10);
        rx_ready = 1'b0;
        check("fullpop_drain_n", 32'(popped.size()), 32'd5);
        check("fullpop_drain_4", 32'(popped[4]), 32'h24);

        // Short glitch is a false start
        ferr0 = n_ferr;
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        tick(40);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_ferr", 32'(n_ferr - ferr0), 32'd0);

        // Bad stop bit then held-low line: one error pulse only
        send_head(8'h5A, ^8'h5A, 1'b0);
        tick(CPB);
        tick(100);
        uart_rxd = 1'b1;
        tick(20);
        check("break_ferr", 32'(n_ferr - ferr0), 32'd1);
        check("break_count", 32'(fifo_count), 32'd0);
        send_frame(8'h3C);
        tick(10);
        check("after_break_count", 32'(fifo_count), 32'd1);
        check("after_break_data", 32'(rx_data), 32'h3C);
        check("after_break_ferr", 32'(n_ferr - ferr0), 32'd1);
        rx_ready = 1'b1;
        tick(3);
        rx_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        send_head(8'h07, 1'b1, 1'b1);
        uart_rxd = 1'b1;
        tick(CPB + 10);
        check("par_ok_count", 32'(fifo_count), 32'd1);
        check("par_ok_data", 32'(rx_data), 32'h07);
        ferr0 = n_ferr;
        send_head(8'h07, 1'b0, 1'b1);
        uart_rxd = 1'b1;
        tick(CPB + 10);
        check("par_bad_count", 32'(fifo_count), 32'd1);
        check("par_bad_ferr", 32'(n_ferr - ferr0), 32'd1);
        rx_ready = 1'b1;
        tick(3);
        rx_ready = 1'b0;
`endif

        check("final_count", 32'(fifo_count), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
